// File: rtl/sha256_ctrl_pkg.sv
// Shared types and constants for the SHA-256 message sequencer.
package sha256_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        LEN,
        ISSUE,
        WAIT,
        DONE
    } ctrl_state_e;

    typedef enum logic [1:0] {
        RET_FILL,
        RET_PAD,
        RET_FIN
    } ret_state_e;

    localparam logic [15:0] PAD_WORD      = 16'h8000;
    localparam logic [4:0]  LEN_WORD_IDX  = 5'd28;
    localparam int unsigned WORDS_PER_BLK = 32;
    localparam logic [4:0]  LAST_WORD_IDX = 5'(WORDS_PER_BLK - 1);

    // Big-endian slice of the 64-bit message bit length for block words 28..31.
    function automatic logic [15:0] len_word(input logic [63:0] bit_len, input logic [1:0] sel);
        case (sel)
            2'd0:    return bit_len[63:48];
            2'd1:    return bit_len[47:32];
            2'd2:    return bit_len[31:16];
            default: return bit_len[15:0];
        endcase
    endfunction

endpackage

// File: rtl/sha256_msg_ctrl_if.sv
// 16-bit message word stream feeding the SHA-256 sequencer.
interface sha256_msg_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic [1:0]  in_nbytes;

    modport master (output in_valid, in_data, in_last, in_nbytes, input in_ready);
    modport slave  (input in_valid, in_data, in_last, in_nbytes, output in_ready);

endinterface

// File: rtl/sha256_blk_buf.sv
// 512-bit message block register; word k occupies bits [511-16k -: 16].
module sha256_blk_buf (
    input  logic         mclk,
    input  logic         puc_rst,
    input  logic         we_i,
    input  logic [4:0]   idx_i,
    input  logic [15:0]  wdata_i,
    output logic [511:0] block_o
);

    logic [511:0] blk_q;

    // Single word write port into the block image.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            blk_q <= '0;
        end else if (we_i) begin
            blk_q[9'd511 - {idx_i, 4'b0000} -: 16] <= wdata_i;
        end
    end

    assign block_o = blk_q;

endmodule

// File: rtl/sha256_msg_ctrl.sv
// Packs a 16-bit word stream into padded 512-bit blocks and sequences
// sha256_core through init/next until the final digest is valid.
module sha256_msg_ctrl
    import sha256_ctrl_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic             mclk,
    input  logic             puc_rst,
    input  logic             start,
    input  logic             abort,
    sha256_msg_ctrl_if.slave in_if,
    output logic             core_init,
    output logic             core_next,
    output logic             core_mode,
    output logic [511:0]     core_block,
    input  logic             core_ready,
    input  logic             core_digest_valid,
    output logic             busy,
    output logic             done
);

    ctrl_state_e      state_q;
    ret_state_e       ret_q;
    logic [4:0]       word_idx_q;
    logic [LEN_W-1:0] byte_cnt_q;
    logic             first_blk_q;
    logic             pad_pend_q;
    logic             skip_q;
    logic             in_ready_q;
    logic             core_init_q;
    logic             core_next_q;
    logic             busy_q;
    logic             done_q;

    logic             accept_s;
    logic             buf_we_s;
    logic [15:0]      buf_wdata_s;
    logic [63:0]      bit_len_s;

    assign accept_s  = in_if.in_valid & in_ready_q;
    assign bit_len_s = {61'(byte_cnt_q), 3'b000};

    // Block write source: stream data in FILL, filler in PAD, bit length in LEN.
    always_comb begin
        buf_we_s    = 1'b0;
        buf_wdata_s = 16'h0000;
        case (state_q)
            FILL: begin
                if (accept_s && !(in_if.in_last && (in_if.in_nbytes == 2'd0))) begin
                    buf_we_s = 1'b1;
                    if (in_if.in_last && (in_if.in_nbytes == 2'd1)) begin
                        buf_wdata_s = {in_if.in_data[15:8], 8'h80};
                    end else begin
                        buf_wdata_s = in_if.in_data;
                    end
                end else begin
                    buf_we_s = 1'b0;
                end
            end
            PAD: begin
                if ((word_idx_q == LEN_WORD_IDX) && !pad_pend_q) begin
                    buf_we_s = 1'b0;
                end else begin
                    buf_we_s    = 1'b1;
                    buf_wdata_s = pad_pend_q ? PAD_WORD : 16'h0000;
                end
            end
            LEN: begin
                buf_we_s    = 1'b1;
                buf_wdata_s = len_word(bit_len_s, word_idx_q[1:0]);
            end
            default: buf_we_s = 1'b0;
        endcase
    end

    sha256_blk_buf u_blk_buf (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .we_i    (buf_we_s),
        .idx_i   (word_idx_q),
        .wdata_i (buf_wdata_s),
        .block_o (core_block)
    );

    // Sequencer: counters, padding progress and core handshake.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q     <= IDLE;
            ret_q       <= RET_FILL;
            word_idx_q  <= 5'd0;
            byte_cnt_q  <= '0;
            first_blk_q <= 1'b1;
            pad_pend_q  <= 1'b0;
            skip_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            core_init_q <= 1'b0;
            core_next_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            core_init_q <= 1'b0;
            core_next_q <= 1'b0;
            if (abort) begin
                state_q    <= IDLE;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (start) begin
                            state_q     <= FILL;
                            word_idx_q  <= 5'd0;
                            byte_cnt_q  <= '0;
                            first_blk_q <= 1'b1;
                            pad_pend_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b1;
                            done_q      <= 1'b0;
                        end
                    end
                    FILL: begin
                        if (accept_s && !in_if.in_last) begin
                            byte_cnt_q <= byte_cnt_q + LEN_W'(2'd2);
                            word_idx_q <= word_idx_q + 5'd1;
                            if (word_idx_q == LAST_WORD_IDX) begin
                                state_q    <= ISSUE;
                                ret_q      <= RET_FILL;
                                in_ready_q <= 1'b0;
                            end
                        end else if (accept_s) begin
                            // A final word that completes the block must be issued before padding.
                            in_ready_q <= 1'b0;
                            ret_q      <= RET_PAD;
                            case (in_if.in_nbytes)
                                2'd0: begin
                                    pad_pend_q <= 1'b1;
                                    state_q    <= PAD;
                                end
                                2'd1: begin
                                    byte_cnt_q <= byte_cnt_q + LEN_W'(2'd1);
                                    word_idx_q <= word_idx_q + 5'd1;
                                    pad_pend_q <= 1'b0;
                                    state_q    <= (word_idx_q == LAST_WORD_IDX) ? ISSUE : PAD;
                                end
                                default: begin
                                    byte_cnt_q <= byte_cnt_q + LEN_W'(2'd2);
                                    word_idx_q <= word_idx_q + 5'd1;
                                    pad_pend_q <= 1'b1;
                                    state_q    <= (word_idx_q == LAST_WORD_IDX) ? ISSUE : PAD;
                                end
                            endcase
                        end
                    end
                    PAD: begin
                        if ((word_idx_q == LEN_WORD_IDX) && !pad_pend_q) begin
                            state_q <= LEN;
                        end else begin
                            pad_pend_q <= 1'b0;
                            word_idx_q <= word_idx_q + 5'd1;
                            if (word_idx_q == LAST_WORD_IDX) begin
                                state_q <= ISSUE;
                                ret_q   <= RET_PAD;
                            end
                        end
                    end
                    LEN: begin
                        word_idx_q <= word_idx_q + 5'd1;
                        if (word_idx_q == LAST_WORD_IDX) begin
                            state_q <= ISSUE;
                            ret_q   <= RET_FIN;
                        end
                    end
                    ISSUE: begin
                        if (core_ready) begin
                            core_init_q <= first_blk_q;
                            core_next_q <= ~first_blk_q;
                            first_blk_q <= 1'b0;
                            skip_q      <= 1'b1;
                            state_q     <= WAIT;
                        end
                    end
                    WAIT: begin
                        // core_ready still reflects the pre-pulse idle state for one cycle.
                        if (skip_q) begin
                            skip_q <= 1'b0;
                        end else if (core_ready) begin
                            case (ret_q)
                                RET_FIN: begin
                                    if (core_digest_valid) begin
                                        state_q <= DONE;
                                        busy_q  <= 1'b0;
                                        done_q  <= 1'b1;
                                    end
                                end
                                RET_FILL: begin
                                    state_q    <= FILL;
                                    in_ready_q <= 1'b1;
                                end
                                default: state_q <= PAD;
                            endcase
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign core_init      = core_init_q;
    assign core_next      = core_next_q;
    assign core_mode      = 1'b1;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Directed bench: behavioural SHA-256 core plus a block scoreboard fed from
// an independent FIPS 180-4 padding model.
module tb_sha256_msg_ctrl;

    logic         mclk = 1'b0;
    logic         puc_rst, start, abort;
    logic         core_init, core_next, core_mode, core_ready, core_digest_valid;
    logic         busy, done;
    logic [511:0] core_block;

    sha256_msg_ctrl_if sif ();

    sha256_msg_ctrl #(.LEN_W(32)) dut (
        .mclk              (mclk),
        .puc_rst           (puc_rst),
        .start             (start),
        .abort             (abort),
        .in_if             (sif),
        .core_init         (core_init),
        .core_next         (core_next),
        .core_mode         (core_mode),
        .core_block        (core_block),
        .core_ready        (core_ready),
        .core_digest_valid (core_digest_valid),
        .busy              (busy),
        .done              (done)
    );

    always #5 mclk = ~mclk;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    logic [7:0]   msg_q[$];
    logic [512:0] exp_q[$];
    logic [512:0] mon_e;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_blk(input logic [255:0] h_in, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        {a, b, c, d, e, f, g, h} = h_in;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h_in[255:224] + a, h_in[223:192] + b, h_in[191:160] + c, h_in[159:128] + d,
                h_in[127:96] + e, h_in[95:64] + f, h_in[63:32] + g, h_in[31:0] + h};
    endfunction

    // Behavioural core: busy for 6 cycles per block, digest held in h_st.
    logic         core_rdy_m, core_dv, hold_ready;
    logic [3:0]   core_cnt;
    logic [255:0] h_st;
    assign core_ready        = core_rdy_m & ~hold_ready;
    assign core_digest_valid = core_dv;

    always @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            core_rdy_m <= 1'b1; core_dv <= 1'b0; core_cnt <= 4'd0; h_st <= '0;
        end else if (core_init || core_next) begin
            h_st       <= sha_blk(core_init ? IV : h_st, core_block);
            core_rdy_m <= 1'b0; core_dv <= 1'b0; core_cnt <= 4'd6;
        end else if (core_cnt != 4'd0) begin
            core_cnt <= core_cnt - 4'd1;
            if (core_cnt == 4'd1) begin
                core_rdy_m <= 1'b1; core_dv <= 1'b1;
            end
        end
    end

    // Scoreboard: every pulse must match the next expected block and pulse kind.
    always @(negedge mclk) begin
        if (core_init || core_next) begin
            pulses++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pulse observed init=%0b next=%0b expected none", core_init, core_next);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                assert ({core_init, core_next} === {mon_e[512], ~mon_e[512]}) else begin
                    errors++;
                    $error("FAIL pulse_kind observed=%b expected=%b", {core_init, core_next}, {mon_e[512], ~mon_e[512]});
                end
                checks++;
                assert (core_block === mon_e[511:0]) else begin
                    errors++;
                    $error("FAIL block observed=%h expected=%h", core_block, mon_e[511:0]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_str(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    task automatic load_rand(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
    endtask

    task automatic push_exp();
        logic [7:0]   p[$];
        logic [63:0]  bl;
        logic [511:0] blk;
        p = msg_q;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg_q.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        for (int bk = 0; bk < p.size() / 64; bk++) begin
            for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*bk + j];
            exp_q.push_back({(bk == 0), blk});
        end
    endtask

    function automatic int nwords();
        return (msg_q.size() == 0) ? 1 : (msg_q.size() + 1) / 2;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge mclk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input logic l, input logic [1:0] nb);
        int c;
        c = 0;
        sif.in_valid = 1'b1; sif.in_data = d; sif.in_last = l; sif.in_nbytes = nb;
        while (!sif.in_ready && c < 500) begin
            @(negedge mclk);
            c++;
        end
        chk("in_ready_wait", c < 500, 1'b1);
        @(negedge mclk);
        sif.in_valid = 1'b0;
    endtask

    task automatic send_range(input int wf, input int wt);
        int len, nw;
        logic [7:0] b0, b1;
        logic l;
        logic [1:0] nb;
        len = msg_q.size();
        nw  = nwords();
        for (int w = wf; w <= wt; w++) begin
            l = (w == nw - 1);
            if (2*w < len) b0 = msg_q[2*w]; else b0 = 8'($urandom);
            if (2*w + 1 < len) b1 = msg_q[2*w + 1]; else b1 = 8'($urandom);
            if (len == 0) nb = 2'd0;
            else if (l && (len % 2 == 1)) nb = 2'd1;
            else nb = 2'd2;
            send_word({b0, b1}, l, nb);
        end
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (!done && c < 2000) begin
            @(negedge mclk);
            c++;
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    int   p0, c0;
    logic seen_rdy, seen_pulse;

    initial begin
        puc_rst = 1'b1; start = 1'b0; abort = 1'b0; hold_ready = 1'b0;
        sif.in_valid = 1'b0; sif.in_data = 16'h0000; sif.in_last = 1'b0; sif.in_nbytes = 2'd0;
        repeat (3) @(negedge mclk);
        chk("rst_init", core_init, 1'b0);
        chk("rst_next", core_next, 1'b0);
        chk("rst_mode", core_mode, 1'b1);
        chk("rst_in_ready", sif.in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_block", core_block, 512'd0);
        puc_rst = 1'b0;
        @(negedge mclk);

        // "abc": one block, odd final byte.
        load_str("abc");
        pulse_start();
        chk("fill_busy", busy, 1'b1);
        chk("fill_in_ready", sif.in_ready, 1'b1);
        push_exp();
        send_range(0, nwords() - 1);
        wait_done("abc");
        chk("abc_digest", h_st, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        // Empty message from DONE.
        load_str("");
        pulse_start();
        push_exp();
        send_range(0, 0);
        wait_done("empty");
        chk("empty_digest", h_st, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);

        // 56 bytes: padding spills into a second block; start while busy is ignored.
        load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        pulse_start();
        push_exp();
        send_range(0, 9);
        pulse_start();
        send_range(10, nwords() - 1);
        wait_done("m56");
        chk("m56_digest", h_st, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);

        // 64 bytes: data-only first block, pulse one cycle after the 32nd word.
        load_rand(64);
        pulse_start();
        push_exp();
        send_range(0, 31);
        chk("m64_in_ready_low", sif.in_ready, 1'b0);
        @(negedge mclk);
        chk("m64_latency_init", core_init, 1'b1);
        wait_done("m64");

        // Core backpressure between blocks of a 70-byte message.
        load_rand(70);
        hold_ready = 1'b1;
        pulse_start();
        push_exp();
        send_range(0, 31);
        p0 = pulses; seen_rdy = 1'b0; seen_pulse = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge mclk);
            seen_rdy   = seen_rdy | sif.in_ready;
            seen_pulse = seen_pulse | core_init | core_next;
        end
        chk("bp_in_ready", seen_rdy, 1'b0);
        chk("bp_pulse", seen_pulse, 1'b0);
        chk("bp_block", core_block, exp_q[0][511:0]);
        chk("bp_busy", busy, 1'b1);
        hold_ready = 1'b0;
        send_range(32, nwords() - 1);
        wait_done("bp");
        chk("bp_pulse_count", pulses - p0, 2);

        // Abort during PAD (start in the same cycle loses), then abort+start in IDLE.
        load_str("abc");
        pulse_start();
        send_range(0, nwords() - 1);
        repeat (3) @(negedge mclk);
        abort = 1'b1; start = 1'b1;
        @(negedge mclk);
        abort = 1'b0; start = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_in_ready", sif.in_ready, 1'b0);
        abort = 1'b1; start = 1'b1;
        @(negedge mclk);
        abort = 1'b0; start = 1'b0;
        chk("abort_wins_busy", busy, 1'b0);
        p0 = pulses;
        repeat (100) @(negedge mclk);
        chk("abort_no_pulse", pulses - p0, 0);

        // Reset while waiting on the core.
        load_str("abc");
        pulse_start();
        push_exp();
        send_range(0, nwords() - 1);
        p0 = pulses; c0 = 0;
        while (pulses == p0 && c0 < 200) begin
            @(negedge mclk);
            c0++;
        end
        chk("rst_pulse_seen", pulses != p0, 1'b1);
        @(negedge mclk);
        puc_rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_block", core_block, 512'd0);
        @(negedge mclk);
        puc_rst = 1'b0;
        p0 = pulses;
        repeat (50) @(negedge mclk);
        chk("midrst_no_pulse", pulses - p0, 0);

        load_str("abc");
        pulse_start();
        push_exp();
        send_range(0, nwords() - 1);
        wait_done("abc2");
        chk("abc2_digest", h_st, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
